// File: rtl/prog_loader.sv
// prog_loader -- boot-time program loader for the 16-bit pipelined CPU.
//
// Holds the CPU in reset (cpu_run=0) while a byte stream arrives over a
// valid/ready handshake, assembles big-endian 16-bit instruction words and
// writes them into the instruction memory, then releases the CPU.
//
// Image format (big-endian): length N (2 bytes), N words (2 bytes each),
// then an optional checksum byte.
//
// Build option: define PROG_LOADER_CSUM_EN to require a trailing checksum
// byte. The modulo-256 sum of every accepted byte, checksum included, must be
// 0x00 or the loader parks in ERR. Without the macro there is no checksum
// state and no sum register.
//
// All outputs are registered. Reset is asynchronous and active-low on rst.

module prog_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              error
);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
`ifdef PROG_LOADER_CSUM_EN
      S_CSUM,
`endif
      S_RUN,
      S_ERR
   } state_t;

   // State entered once the last data word (or a zero length) is in.
`ifdef PROG_LOADER_CSUM_EN
   localparam state_t S_DONE = S_CSUM;
`else
   localparam state_t S_DONE = S_RUN;
`endif

   // Memory capacity in words; N equal to this is legal, larger is an error.
   localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

   // Registered state and outputs
   state_t              state_q,      state_d;
   logic [15:0]         len_q,        len_d;
   logic [ADDR_W:0]     cnt_q,        cnt_d;
   logic [7:0]          hold_q,       hold_d;
   logic                in_ready_q,   in_ready_d;
   logic                imem_we_q,    imem_we_d;
   logic [ADDR_W-1:0]   imem_addr_q,  imem_addr_d;
   logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
   logic                cpu_run_q,    cpu_run_d;
   logic                busy_q,       busy_d;
   logic                error_q,      error_d;
`ifdef PROG_LOADER_CSUM_EN
   logic [7:0]          sum_q,        sum_d;
   logic [7:0]          sum_new;
`endif

   // Combinational helpers
   logic                accept;
   logic [15:0]         len_new;
   logic [15:0]         cnt_inc;
   logic                load_next;

   // Next-state logic: byte acceptance, word assembly and output decode.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; an unassigned path in always_comb would infer a latch.
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;

      // A byte moves only when we advertised ready on the previous edge.
      accept  = in_valid && in_ready_q;
      len_new = {len_q[15:8], in_data};
      cnt_inc = 16'(cnt_q) + 16'd1;

`ifdef PROG_LOADER_CSUM_EN
      sum_new = sum_q + in_data;
      sum_d   = sum_q;
      if (accept) begin
         sum_d = sum_new;
      end
`endif

      case (state_q)
         S_LEN_HI: begin
            if (accept) begin
               len_d[15:8] = in_data;
               state_d     = S_LEN_LO;
            end
         end

         S_LEN_LO: begin
            if (accept) begin
               len_d = len_new;
               if (len_new == 16'd0) begin
                  state_d = S_DONE;
               end else if ({1'b0, len_new} > DEPTH) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA_HI;
               end
            end
         end

         S_DATA_HI: begin
            if (accept) begin
               hold_d  = in_data;
               state_d = S_DATA_LO;
            end
         end

         S_DATA_LO: begin
            if (accept) begin
               // The write strobe appears the cycle after the low byte lands.
               imem_we_d    = 1'b1;
               imem_addr_d  = cnt_q[ADDR_W-1:0];
               imem_wdata_d = {hold_q, in_data};
               cnt_d        = cnt_inc[ADDR_W:0];
               state_d      = (cnt_inc == len_q) ? S_DONE : S_DATA_HI;
            end
         end

`ifdef PROG_LOADER_CSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_d = (sum_new == 8'd0) ? S_RUN : S_ERR;
            end
         end
`endif

         S_RUN, S_ERR: begin
            // Only a parked loader honours reload; it restarts from scratch.
            if (reload) begin
               state_d = S_LEN_HI;
               len_d   = 16'd0;
               cnt_d   = '0;
`ifdef PROG_LOADER_CSUM_EN
               sum_d   = 8'd0;
`endif
            end
         end

         default: begin
            state_d = S_LEN_HI;
         end
      endcase

      // Status outputs are decoded from the next state so they are registered
      // yet line up with the state they describe.
      load_next  = (state_d != S_RUN) && (state_d != S_ERR);
      in_ready_d = load_next;
      // LEN_HI is only ever entered fresh, so it never counts as busy.
      busy_d     = load_next && (state_d != S_LEN_HI);
      cpu_run_d  = (state_d == S_RUN);
      error_d    = (state_d == S_ERR);
   end

   // State and output registers; everything returns to idle on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_LEN_HI;
         len_q        <= 16'd0;
         cnt_q        <= '0;
         hold_q       <= 8'd0;
         in_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_run_q    <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
         sum_q        <= 8'd0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge
         // _d values together, independent of statement order.
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         in_ready_q   <= in_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_run_q    <= cpu_run_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
`ifdef PROG_LOADER_CSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign cpu_run    = cpu_run_q;
   assign busy       = busy_q;
   assign error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- self-checking bench for prog_loader.
//
// A byte-stream model (list of accepted bytes since the last reset/reload)
// predicts every output on every cycle; directed images plus literal
// expectations pin the model. Honours PROG_LOADER_CSUM_EN when defined.

module tb_prog_loader;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk      = 1'b0;
   logic              rst      = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data  = 8'd0;
   logic              reload   = 1'b0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;
   logic              cpu_run;
   logic              busy;
   logic              error;

   prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .busy       (busy),
      .error      (error)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- checking
   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------- model
   // The loader's whole behaviour follows from the bytes accepted so far.
   logic [7:0]        m_bytes[$];
   bit                m_fresh = 1'b1;   // first cycle after reset: not ready yet
   bit                m_we    = 1'b0;
   logic [ADDR_W-1:0] m_addr  = '0;
   logic [DATA_W-1:0] m_wdata = '0;

   function automatic void model_status(output bit run_e, output bit err_e);
      int k = m_bytes.size();
      int n;
      run_e = 1'b0;
      err_e = 1'b0;
      if (k < 2) return;
      n = {16'd0, m_bytes[0], m_bytes[1]};
      if (n > DEPTH) begin
         err_e = 1'b1;
         return;
      end
`ifdef PROG_LOADER_CSUM_EN
      if (k == 2 * n + 3) begin
         int s = 0;
         foreach (m_bytes[i]) s += m_bytes[i];
         if (s % 256 == 0) run_e = 1'b1;
         else              err_e = 1'b1;
      end
`else
      if (k == 2 * n + 2) run_e = 1'b1;
`endif
   endfunction

   // Model update on each clock edge (or asynchronous reset).
   initial begin
      bit run_e, err_e;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_bytes.delete();
            m_fresh = 1'b1;
            m_we    = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
         end else begin
            model_status(run_e, err_e);
            m_we = 1'b0;
            if (m_fresh) begin
               m_fresh = 1'b0;
            end else if (run_e || err_e) begin
               if (reload) m_bytes.delete();
            end else if (in_valid) begin
               int k, n;
               m_bytes.push_back(in_data);
               k = m_bytes.size();
               n = (k >= 2) ? {16'd0, m_bytes[0], m_bytes[1]} : 0;
               if (k >= 4 && (k % 2) == 0 && k <= 2 * n + 2) begin
                  m_we    = 1'b1;
                  m_addr  = ADDR_W'((k - 4) / 2);
                  m_wdata = {m_bytes[k-2], m_bytes[k-1]};
               end
            end
         end
      end
   end

   // Compare every output against the model on each falling edge.
   initial begin
      bit run_e, err_e;
      forever begin
         @(negedge clk);
         model_status(run_e, err_e);
         check("in_ready",   in_ready,   !m_fresh && !run_e && !err_e);
         check("busy",       busy,       (m_bytes.size() >= 1) && !run_e && !err_e);
         check("cpu_run",    cpu_run,    run_e);
         check("error",      error,      err_e);
         check("imem_we",    imem_we,    m_we);
         check("imem_addr",  imem_addr,  m_addr);
         check("imem_wdata", imem_wdata, m_wdata);
      end
   end

   // Observed instruction memory, built from the write strobes.
   logic [DATA_W-1:0] obs_mem[DEPTH];
   int                obs_writes = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (imem_we === 1'b1) begin
            obs_mem[imem_addr] = imem_wdata;
            obs_writes++;
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   logic [7:0] stim[$];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && waited < 20) begin
         step(1);
         waited++;
      end
      check("in_ready_wait", in_ready, 1);
      step(1);
   endtask

   task automatic send_stim();
      foreach (stim[i]) send_byte(stim[i]);
      in_valid = 1'b0;
      stim.delete();
   endtask

   // Sends a complete image, adding the checksum byte when that build is on.
   task automatic send_image();
`ifdef PROG_LOADER_CSUM_EN
      logic [7:0] s = 8'd0;
      foreach (stim[i]) s += stim[i];
      stim.push_back(8'd0 - s);
`endif
      send_stim();
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      step(1);
      reload = 1'b0;
   endtask

   initial begin
      int w0;

      // Reset and its output values.
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_in_ready", in_ready, 0);
      check("rst_cpu_run",  cpu_run,  0);
      check("rst_busy",     busy,     0);
      @(posedge clk);
      #1 rst = 1'b1;

      // Two-word image, back to back.
      w0 = obs_writes;
      stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      send_image();
      check("t1_cpu_run_latency", cpu_run, 1);
`ifndef PROG_LOADER_CSUM_EN
      check("t1_last_we",    imem_we,    1);
      check("t1_last_addr",  imem_addr,  1);
      check("t1_last_wdata", imem_wdata, 16'hABCD);
`endif
      step(2);
      check("t1_writes",   obs_writes - w0, 2);
      check("t1_mem0",     obs_mem[0], 16'h1234);
      check("t1_mem1",     obs_mem[1], 16'hABCD);
      check("t1_in_ready", in_ready, 0);

      // Zero-length image.
      pulse_reload();
      check("t2_reload_drop", cpu_run, 0);
      w0 = obs_writes;
      stim = '{8'h00, 8'h00};
      send_image();
      step(2);
      check("t2_cpu_run", cpu_run, 1);
      check("t2_writes",  obs_writes - w0, 0);
`ifdef PROG_LOADER_CSUM_EN
      pulse_reload();
      stim = '{8'h00, 8'h00, 8'h01};
      send_stim();
      step(2);
      check("t2_csum_err",     error,   1);
      check("t2_csum_cpu_run", cpu_run, 0);
`endif

      // Oversize length: 257 words.
      pulse_reload();
      w0 = obs_writes;
      stim = '{8'h01, 8'h01};
      send_stim();
      check("t3_error",    error,    1);
      check("t3_in_ready", in_ready, 0);
      step(2);
      check("t3_writes",  obs_writes - w0, 0);
      check("t3_cpu_run", cpu_run, 0);

      // Stalls and an ignored reload during loading.
      pulse_reload();
      check("t4_error_clr", error, 0);
      w0 = obs_writes;
      send_byte(8'h00);
      in_valid = 1'b0;
      reload   = 1'b1;
      step(1);
      reload   = 1'b0;
      step(1);
      check("t4_busy_stall", busy, 1);
      send_byte(8'h01);
      in_valid = 1'b0;
      step(2);
      send_byte(8'hAA);
      in_valid = 1'b0;
      step(2);
      check("t4_no_write", obs_writes - w0, 0);
      send_byte(8'h55);
`ifdef PROG_LOADER_CSUM_EN
      send_byte(8'h00);
`endif
      in_valid = 1'b0;
      step(2);
      check("t4_writes",  obs_writes - w0, 1);
      check("t4_mem0",    obs_mem[0], 16'hAA55);
      check("t4_cpu_run", cpu_run, 1);

      // Full-capacity image: exactly 2^ADDR_W words.
      pulse_reload();
      w0 = obs_writes;
      stim = '{8'h01, 8'h00};
      for (int i = 0; i < DEPTH; i++) begin
         stim.push_back(8'(i));
         stim.push_back(8'(i) ^ 8'hA5);
      end
      send_image();
      step(2);
      check("t5_writes",   obs_writes - w0, 256);
      check("t5_mem0",     obs_mem[0],   16'h00A5);
      check("t5_mem255",   obs_mem[255], 16'hFF5A);
      check("t5_cpu_run",  cpu_run, 1);

      // Reset in the middle of a load.
      pulse_reload();
      stim = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
      send_stim();
      step(1);
      check("t6_mem0_partial", obs_mem[0], 16'h1122);
      #2 rst = 1'b0;
      #1;
      check("t6_rst_in_ready",   in_ready,   0);
      check("t6_rst_cpu_run",    cpu_run,    0);
      check("t6_rst_imem_we",    imem_we,    0);
      check("t6_rst_busy",       busy,       0);
      check("t6_rst_error",      error,      0);
      check("t6_rst_imem_addr",  imem_addr,  0);
      check("t6_rst_imem_wdata", imem_wdata, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      stim = '{8'h00, 8'h01, 8'hBE, 8'hEF};
      send_image();
      step(2);
      check("t6_mem0",    obs_mem[0], 16'hBEEF);
      check("t6_mem1",    obs_mem[1], 16'h01A4);
      check("t6_cpu_run", cpu_run, 1);

      // Reload from RUN and overwrite address 0.
      pulse_reload();
      check("t7_reload_drop", cpu_run,  0);
      check("t7_ready",       in_ready, 1);
      stim = '{8'h00, 8'h01, 8'h00, 8'h07};
      send_image();
      step(2);
      check("t7_mem0",    obs_mem[0], 16'h0007);
      check("t7_cpu_run", cpu_run, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Bound on total run time.
   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
